// File: rtl/byte_striping.sv
// Stripes consecutive valid words alternately onto two lanes, held for two cycles per pair.
// Optional STRIPE_FLUSH_EN adds an idle timeout that flushes a lone word onto lane_0.
module byte_striping #(
  parameter int unsigned BUS_WIDTH    = 32,
  parameter int unsigned FLUSH_CYCLES = 4
) (
  input  logic                 clk_2f,
  input  logic                 reset,
  input  logic [BUS_WIDTH-1:0] data_in,
  input  logic                 valid_in,
  output logic [BUS_WIDTH-1:0] lane_0,
  output logic [BUS_WIDTH-1:0] lane_1,
  output logic                 valid_0,
  output logic                 valid_1,
  output logic                 pair_strobe
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_HALF  = 1'b1;

  if ((FLUSH_CYCLES < 1) || (FLUSH_CYCLES > 15)) begin : g_bad_flush_cycles
    $error("byte_striping: FLUSH_CYCLES must be within 1..15");
  end

  logic [0:0]           r_state;
  logic [0:0]           w_next_state;
  logic [BUS_WIDTH-1:0] r_hold;
  logic                 r_vhold_cnt;
  logic                 w_load_hold;
  logic                 w_pair;
  logic                 w_flush;
  logic                 w_idle_done;

`ifdef STRIPE_FLUSH_EN
  localparam int unsigned IDLE_W = 4;

  logic [IDLE_W-1:0] r_idle;

  assign w_idle_done = (r_idle == IDLE_W'(FLUSH_CYCLES));

  // Counts idle cycles while a lone word waits in HALF; cleared otherwise.
  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      r_idle <= '0;
    end else if ((r_state == ST_HALF) && !valid_in) begin
      r_idle <= r_idle + IDLE_W'(1);
    end else begin
      r_idle <= '0;
    end
  end
`else
  assign w_idle_done = 1'b0;
`endif

  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  // A new word in HALF always wins over the timeout, so flush only fires when idle.
  always_comb begin
    w_next_state = r_state;
    w_load_hold  = 1'b0;
    w_pair       = 1'b0;
    w_flush      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (valid_in) begin
          w_load_hold  = 1'b1;
          w_next_state = ST_HALF;
        end
      end
      ST_HALF: begin
        if (valid_in) begin
          w_pair       = 1'b1;
          w_next_state = ST_EMPTY;
        end else if (w_idle_done) begin
          w_flush      = 1'b1;
          w_next_state = ST_EMPTY;
        end
      end
      default: w_next_state = ST_EMPTY;
    endcase
  end

  // Lane data persists until the next strobe; valid flags live for two cycles after it.
  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      r_hold      <= '0;
      r_vhold_cnt <= 1'b0;
      lane_0      <= '0;
      lane_1      <= '0;
      valid_0     <= 1'b0;
      valid_1     <= 1'b0;
      pair_strobe <= 1'b0;
    end else begin
      if (w_load_hold) begin
        r_hold <= data_in;
      end
      pair_strobe <= w_pair | w_flush;
      if (w_pair || w_flush) begin
        lane_0      <= r_hold;
        lane_1      <= w_pair ? data_in : '0;
        valid_0     <= 1'b1;
        valid_1     <= w_pair;
        r_vhold_cnt <= 1'b1;
      end else if (r_vhold_cnt) begin
        r_vhold_cnt <= 1'b0;
      end else begin
        valid_0 <= 1'b0;
        valid_1 <= 1'b0;
      end
    end
  end

endmodule
